sr_pulse_driver: RTL and testbench

- Upstream driver for the gate-level SR latch.
- Takes two raw, bouncy push-button inputs (set, reset), then synchronises, debounces and edge-detects them.
- Emits clean, fixed-width, mutually exclusive S/R pulses with a guaranteed idle gap, so the latch never sees S=R=1.
- Flags any simultaneous set/reset request as a conflict instead of forwarding it.

---
 rtl/sr_pkg.sv | 31 +++
 rtl/sr_pulse_driver_if.sv | 30 +++
 rtl/sr_debounce.sv | 56 +++++
 rtl/sr_pulse_driver.sv | 130 +++++++++++++
 tb/tb_sr_pulse_driver.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR latch pulse driver: FSM state codes,
// command encoding and the pending-command record.
package sr_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PULSE_S = 2'd1;
    localparam logic [1:0] ST_PULSE_R = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    typedef logic [1:0] state_t;

    typedef enum logic {
        CMD_SET = 1'b0,
        CMD_RST = 1'b1
    } cmd_e;

    typedef struct packed {
        logic v;
        cmd_e cmd;
    } pend_t;

    // Width able to hold 0..n-1 with one bit of headroom; never below 1.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic state_t cmd2state(input cmd_e c);
        return (c == CMD_SET) ? ST_PULSE_S : ST_PULSE_R;
    endfunction

endpackage

// File: rtl/sr_pulse_driver_if.sv
// Button inputs and latch-side outputs of the pulse driver, bundled so the
// driver and its environment share one connection.
interface sr_pulse_driver_if;

    logic set_btn;
    logic reset_btn;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    modport master (
        output set_btn,
        output reset_btn,
        input  S,
        input  R,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_btn,
        input  reset_btn,
        output S,
        output R,
        output busy,
        output conflict
    );

endinterface

// File: rtl/sr_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a single-cycle request on each debounced rising edge.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic req_o
);

    localparam int CW = cnt_w(DEB_CYCLES);

    logic          s1_q;
    logic          s2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample matching the current level restarts the stability window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= btn_i;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign req_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/sr_pulse_driver.sv
// Turns debounced set/reset button presses into fixed-width, mutually
// exclusive S/R pulses separated by an idle gap, with a one-deep command queue.
module sr_pulse_driver
    import sr_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic               clk,
    input  logic               rst,
    sr_pulse_driver_if.slave   bus
);

    localparam int PG_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW     = cnt_w(PG_MAX);

    logic          set_req;
    logic          rst_req;
    logic          both_req;
    logic          one_req;
    cmd_e          req_cmd;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    pend_t         pend_q;
    pend_t         pend_d;

    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          conflict_q;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk   (clk),
        .rst   (rst),
        .btn_i (bus.set_btn),
        .req_o (set_req)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .clk   (clk),
        .rst   (rst),
        .btn_i (bus.reset_btn),
        .req_o (rst_req)
    );

    // Coincident requests cancel each other; only a lone request is a command.
    assign both_req = set_req & rst_req;
    assign one_req  = set_req ^ rst_req;
    assign req_cmd  = set_req ? CMD_SET : CMD_RST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (one_req) begin
                    state_d = cmd2state(req_cmd);
                    cnt_d   = '0;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (one_req) begin
                    pend_d = '{v: 1'b1, cmd: req_cmd};
                end
                if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (one_req) begin
                    pend_d = '{v: 1'b1, cmd: req_cmd};
                end
                // A request on the final gap cycle lands in pend_d first, so it
                // is the one issued on this edge.
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (pend_d.v) begin
                        state_d  = cmd2state(pend_d.cmd);
                        pend_d.v = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are flops loaded from the next state, so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            s_q        <= (state_d == ST_PULSE_S);
            r_q        <= (state_d == ST_PULSE_R);
            busy_q     <= (state_d != ST_IDLE);
            conflict_q <= both_req;
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;

    a_no_sr_overlap: assert property (@(posedge clk) disable iff (rst) !(s_q && r_q));

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver: a vector table for single-press
// behaviour plus hand-built sequences for queueing and asynchronous reset.
module tb_sr_pulse_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sr_pulse_driver_if b1 ();
    sr_pulse_driver_if b2 ();

    sr_pulse_driver u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Long pulses give room for two requests to land inside one pulse.
    sr_pulse_driver #(
        .DEB_CYCLES   (4),
        .PULSE_CYCLES (12),
        .GAP_CYCLES   (2)
    ) u_long (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic set_b;
        logic rst_b;
        logic s;
        logic r;
        logic busy;
        logic conf;
    } vec_t;

    vec_t vecs[$];

    int n_chk   = 0;
    int n_fail  = 0;
    int inv_bad = 0;
    logic p1s = 1'b0, p1r = 1'b0, p2s = 1'b0, p2r = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic add_n(input int n, input logic sb, input logic rb,
                         input logic s, input logic r, input logic b, input logic c);
        for (int i = 0; i < n; i++) vecs.push_back('{sb, rb, s, r, b, c});
    endtask

    task automatic step(input logic s1, input logic r1, input logic s2, input logic r2);
        b1.set_btn   = s1;
        b1.reset_btn = r1;
        b2.set_btn   = s2;
        b2.reset_btn = r2;
        @(posedge clk);
        @(negedge clk);
    endtask

    // S/R exclusivity and no S->R or R->S hand-over without an idle cycle.
    always @(negedge clk) begin
        if (rst) begin
            p1s <= 1'b0; p1r <= 1'b0; p2s <= 1'b0; p2r <= 1'b0;
        end else begin
            if (b1.S && b1.R) inv_bad <= inv_bad + 1;
            if ((b1.S && p1r) || (b1.R && p1s)) inv_bad <= inv_bad + 1;
            if (b2.S && b2.R) inv_bad <= inv_bad + 1;
            if ((b2.S && p2r) || (b2.R && p2s)) inv_bad <= inv_bad + 1;
            p1s <= b1.S; p1r <= b1.R; p2s <= b2.S; p2r <= b2.R;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] st, rt, bt, ct;

        b1.set_btn = 1'b0; b1.reset_btn = 1'b0;
        b2.set_btn = 1'b0; b2.reset_btn = 1'b0;

        // Reset state, observed before any clock edge.
        #1 rst = 1'b1;
        #2;
        chk("rst_S",        b1.S,        1'b0);
        chk("rst_R",        b1.R,        1'b0);
        chk("rst_busy",     b1.busy,     1'b0);
        chk("rst_conflict", b1.conflict, 1'b0);
        chk("rst_long_busy", b2.busy,    1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Clean set press held 10 cycles.
        add_n(6, 1, 0, 0, 0, 0, 0);
        add_n(2, 1, 0, 1, 0, 1, 0);
        add_n(1, 1, 0, 0, 0, 1, 0);
        add_n(1, 1, 0, 0, 0, 0, 0);
        add_n(8, 0, 0, 0, 0, 0, 0);
        // Bounce 1,0,1,0 then settle low: nothing happens.
        add_n(1, 1, 0, 0, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 0, 0);
        add_n(1, 1, 0, 0, 0, 0, 0);
        add_n(7, 0, 0, 0, 0, 0, 0);
        // Then a 5-cycle hold yields one S pulse.
        add_n(5, 1, 0, 0, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 0, 0);
        add_n(2, 0, 0, 1, 0, 1, 0);
        add_n(1, 0, 0, 0, 0, 1, 0);
        add_n(10, 0, 0, 0, 0, 0, 0);
        // Simultaneous set and reset: one conflict cycle, no pulse.
        add_n(6, 1, 1, 0, 0, 0, 0);
        add_n(1, 1, 1, 0, 0, 0, 1);
        add_n(3, 1, 1, 0, 0, 0, 0);
        add_n(8, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].set_b, vecs[i].rst_b, 1'b0, 1'b0);
            chk($sformatf("vec%0d_S", i),        b1.S,        vecs[i].s);
            chk($sformatf("vec%0d_R", i),        b1.R,        vecs[i].r);
            chk($sformatf("vec%0d_busy", i),     b1.busy,     vecs[i].busy);
            chk($sformatf("vec%0d_conflict", i), b1.conflict, vecs[i].conf);
        end

        // Reset request debounced during PULSE_S is queued behind the set.
        st = '0; rt = '0; bt = '0; ct = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i >= 1), 1'b0, 1'b0);
            st[i] = b1.S; rt[i] = b1.R; bt[i] = b1.busy; ct[i] = b1.conflict;
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("queued_S_trace",    st, mask(6, 7));
        chk("queued_R_trace",    rt, mask(9, 10));
        chk("queued_busy_trace", bt, mask(6, 11));
        chk("queued_conflict",   ct, 64'd0);

        // Reset then set request during one long pulse: only the set is issued.
        st = '0; rt = '0; bt = '0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, (i < 4) || (i >= 8 && i < 12), (i >= 2 && i < 6));
            st[i] = b2.S; rt[i] = b2.R; bt[i] = b2.busy;
        end
        chk("lastwins_S_trace",    st, mask(6, 17) | mask(20, 31));
        chk("lastwins_R_trace",    rt, 64'd0);
        chk("lastwins_busy_trace", bt, mask(6, 33));

        // Asynchronous reset in the middle of PULSE_R with a set pending.
        for (int i = 0; i < 8; i++) step((i >= 1), 1'b1, 1'b0, 1'b0);
        chk("midrst_R_before", b1.R,    1'b1);
        chk("midrst_busy_before", b1.busy, 1'b1);
        #2;
        rst = 1'b1;
        b1.set_btn = 1'b0; b1.reset_btn = 1'b0;
        #1;
        chk("midrst_R_async",    b1.R,    1'b0);
        chk("midrst_busy_async", b1.busy, 1'b0);
        chk("midrst_S_async",    b1.S,    1'b0);
        @(negedge clk);
        rst = 1'b0;
        st = '0; rt = '0; bt = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            st[i] = b1.S; rt[i] = b1.R; bt[i] = b1.busy;
        end
        chk("postrst_S_trace",    st, 64'd0);
        chk("postrst_R_trace",    rt, 64'd0);
        chk("postrst_busy_trace", bt, 64'd0);

        chk("sr_invariant_violations", 64'(inv_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
